// File: rtl/ibex_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle single-port RAM between the
// Ibex fetch and data ports, with an address-window check and error response.
module ibex_mem_arbiter #(
  parameter logic [31:0] AddrBase = 32'h8000_0000,
  parameter logic [31:0] AddrMask = 32'h0000_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic [15:0] conflict_cnt_o
);

  logic        rr_q, rr_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_host_q, resp_host_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt_i, gnt_d, any_gnt, both;
  logic        in_range;
  logic [31:0] sel_addr;

  always_comb begin
    both     = instr_req_i && data_req_i;
    // rr_q = 1 gives the fetch port priority under contention
    gnt_i    = rst_ni && instr_req_i && (!data_req_i || rr_q);
    gnt_d    = rst_ni && data_req_i && (!instr_req_i || !rr_q);
    any_gnt  = gnt_i || gnt_d;
    sel_addr = gnt_d ? data_addr_i : instr_addr_i;
    in_range = (sel_addr >= AddrBase) &&
               (sel_addr <= AddrBase + AddrMask);
  end

  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (any_gnt && in_range) begin
      ram_req_o  = 1'b1;
      ram_addr_o = sel_addr - AddrBase;
      unique case (1'b1)
        gnt_d: begin
          ram_we_o    = data_we_i;
          ram_be_o    = data_be_i;
          ram_wdata_o = data_wdata_i;
        end
        gnt_i: begin
          ram_be_o = 4'hF;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rr_d         = rr_q;
    resp_valid_d = any_gnt;
    resp_host_d  = gnt_d;
    resp_err_d   = any_gnt && !in_range;
    cnt_d        = cnt_q;
    if (both) begin
      rr_d = gnt_d;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_host_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      cnt_q        <= 16'h0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_host_q  <= resp_host_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata          = resp_err_q ? 32'h0 : ram_rdata_i;
    instr_gnt_o    = gnt_i;
    data_gnt_o     = gnt_d;
    instr_rvalid_o = resp_valid_q && !resp_host_q;
    data_rvalid_o  = resp_valid_q && resp_host_q;
    instr_err_o    = instr_rvalid_o && resp_err_q;
    data_err_o     = data_rvalid_o && resp_err_q;
    instr_rdata_o  = instr_rvalid_o ? rdata : 32'h0;
    data_rdata_o   = data_rvalid_o ? rdata : 32'h0;
    conflict_cnt_o = cnt_q;
  end

endmodule
